// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_e;

  localparam int MEM_LAT_DEFAULT    = 2;
  localparam int STARVE_MAX_DEFAULT = 3;

  // Wide enough for the 1..15 legal range of both counters
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data, with a starvation counter that
// forces a fetch win after STARVE_MAX consecutive data wins over it.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic decide_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic winValid_o,
  output src_e winSrc_o
);

  logic [CNT_W-1:0] starveCnt_q;
  logic [CNT_W-1:0] starveCnt_d;
  logic             forceFetch;

  // Pick the winner: data by default, fetch when alone or when starved too long
  always_comb begin
    forceFetch  = if_req_i && (starveCnt_q == CNT_W'(STARVE_MAX));
    winValid_o  = if_req_i || d_req_i;
    winSrc_o    = SRC_IF;
    if (d_req_i && !forceFetch) begin
      winSrc_o = SRC_D;
    end
  end

  // Next starvation count: only moves on an actual IDLE decision
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (decide_i && winValid_o) begin
      if (winSrc_o == SRC_IF) begin
        starveCnt_d = '0;
      end else if (if_req_i && (starveCnt_q != CNT_W'(STARVE_MAX))) begin
        starveCnt_d = starveCnt_q + CNT_W'(1);
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, data) arbiter in front of a single-port memory with
// fixed read latency. One transaction at a time: IDLE -> ISSUE -> WAIT x MEM_LAT.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = MEM_LAT_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e           state_q;
  src_e             winSrc_q;
  logic             we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0] latCnt_q;

  logic winValid;
  src_e winSrc;
  logic decide;
  logic active;
  logic issue;
  logic lastWait;

  assign decide = (state_q == IDLE) && !reset;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk       (clk),
    .reset     (reset),
    .decide_i  (decide),
    .if_req_i  (if_req),
    .d_req_i   (d_req),
    .winValid_o(winValid),
    .winSrc_o  (winSrc)
  );

  // Transaction FSM: latch the winner in IDLE, strobe memory in ISSUE, then count out the latency
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      winSrc_q <= SRC_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      latCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (winValid) begin
            state_q  <= ISSUE;
            winSrc_q <= winSrc;
            if (winSrc == SRC_D) begin
              we_q    <= d_we;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= if_addr;
              wdata_q <= '0;
            end
          end
        end
        ISSUE: begin
          state_q  <= WAIT;
          latCnt_q <= '0;
        end
        WAIT: begin
          if (latCnt_q == CNT_W'(MEM_LAT - 1)) begin
            state_q  <= IDLE;
            latCnt_q <= '0;
          end else begin
            latCnt_q <= latCnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode from the state registers; everything is forced low while reset is held
  always_comb begin
    active    = !reset;
    issue     = active && (state_q == ISSUE);
    lastWait  = active && (state_q == WAIT) && (latCnt_q == CNT_W'(MEM_LAT - 1));

    if_gnt    = issue && (winSrc_q == SRC_IF);
    d_gnt     = issue && (winSrc_q == SRC_D);
    mem_en    = issue;
    mem_we    = issue && we_q;
    mem_addr  = issue ? addr_q : '0;
    mem_wdata = issue ? wdata_q : '0;

    if_rvalid = lastWait && (winSrc_q == SRC_IF);
    d_rvalid  = lastWait && (winSrc_q == SRC_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;

    busy      = active && (state_q != IDLE);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL take parameter DATA_W, default 32, meaning data width.
REQ-003 The block SHALL take parameter MEM_LAT, default 2, meaning cycles from memory issue to valid mem_rdata; legal range 1..15.
REQ-004 The block SHALL take parameter STARVE_MAX, default 3, meaning the number of consecutive data wins over a pending fetch before fetch is forced; legal range 1..15.
REQ-005 The block SHALL have these ports:
  clk  in  1  the only clock; all logic on its rising edge
  reset  in  1  synchronous, active-high reset
  if_req  in  1  fetch read request; held until if_gnt
  if_addr  in  ADDR_W  fetch address
  if_gnt  out  1  fetch request accepted (1-cycle pulse)
  if_rvalid  out  1  fetch read data valid (1-cycle pulse)
  if_rdata  out  DATA_W  fetch read data
  d_req  in  1  data request; held until d_gnt
  d_we  in  1  1 = write, 0 = read
  d_addr  in  ADDR_W  data address
  d_wdata  in  DATA_W  write data
  d_gnt  out  1  data request accepted (1-cycle pulse)
  d_rvalid  out  1  data completion or read data valid (1-cycle pulse)
  d_rdata  out  DATA_W  data read data; 0 for writes
  mem_en  out  1  single-port memory access strobe
  mem_we  out  1  memory write enable
  mem_addr  out  ADDR_W  memory address
  mem_wdata  out  DATA_W  memory write data
  mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after mem_en
  busy  out  1  state is not IDLE

Function
REQ-006 The block SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-007 In IDLE with any request pending, the block SHALL latch the winner, its address, we and wdata, then go to ISSUE; with no request it SHALL stay in IDLE.
REQ-008 Winner selection SHALL follow these rules:
  - data beats fetch;
  - exception: when starve_cnt == STARVE_MAX and if_req = 1, fetch wins;
  - a lone requester always wins.
REQ-009 starve_cnt SHALL update on each IDLE decision as follows:
  - increment (saturating at STARVE_MAX) when data wins while if_req = 1;
  - clear to 0 when fetch wins;
  - otherwise unchanged.
REQ-010 ISSUE SHALL last exactly one cycle, during which:
  - mem_en = 1;
  - mem_addr and mem_wdata come from the latched request;
  - mem_we = 1 only for a data write;
  - the winner's gnt = 1.
  Then the FSM goes to WAIT.
REQ-011 WAIT SHALL last exactly MEM_LAT cycles, counted by a latency counter.
REQ-012 On the final WAIT cycle, the block SHALL:
  - assert the winner's rvalid;
  - drive its rdata = mem_rdata for reads, 0 for writes;
  - return to IDLE next cycle.
REQ-013 Outside the rvalid cycle, if_rdata and d_rdata SHALL be 0.
REQ-014 If the owning requester drops its req during ISSUE or WAIT, the transaction SHALL still complete unchanged.
REQ-015 Latency SHALL be: request sampled in IDLE at cycle 0; gnt and mem_en at cycle 1; rvalid at cycle 1+MEM_LAT; IDLE at cycle 2+MEM_LAT.
REQ-016 Throughput SHALL be one transaction per MEM_LAT+2 cycles.
REQ-017 Only one of if_gnt/d_gnt and only one of if_rvalid/d_rvalid SHALL ever be 1 in a given cycle.
REQ-018 mem_en, mem_we, mem_addr and mem_wdata SHALL be 0 outside ISSUE.
REQ-019 busy SHALL equal 1 exactly when the state is not IDLE.

Reset
REQ-020 Reset SHALL be synchronous and active-high on clk, and SHALL take priority over all other logic.
REQ-021 While reset = 1, the block SHALL:
  - set state to IDLE;
  - clear starve_cnt, the latency counter and all latched request registers to 0;
  - drive every output to 0.
REQ-022 Reset mid-transaction SHALL abort the transaction with no rvalid issued.
REQ-023 Arbitration SHALL resume on the first cycle after reset deasserts.

Structure
REQ-024 The package mem_arb_pkg SHALL hold:
  - the FSM state enum (IDLE, ISSUE, WAIT);
  - the source enum (SRC_IF, SRC_D);
  - defaults for MEM_LAT and STARVE_MAX.
REQ-025 Winner selection and starve_cnt SHALL live in one sub-module, mem_arb_prio; the FSM, latency counter and muxing SHALL live in mem_arbiter.

Verification (MEM_LAT=2, STARVE_MAX=3)
REQ-026 Reset held 2 cycles -> every output 0, busy 0.
REQ-027 if_req=1, if_addr=0x00000010 at cycle 0, memory returns 0x00000001 at cycle 3 -> expect:
  - cycle 1: if_gnt=1, mem_en=1, mem_addr=0x10;
  - cycle 3: if_rvalid=1, if_rdata=0x1;
  - cycle 4: busy=0.
REQ-028 d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> expect:
  - cycle 1: d_gnt=1, mem_we=1, mem_wdata=0xDEADBEEF;
  - cycle 3: d_rvalid=1, d_rdata=0.
REQ-029 if_req and d_req held high continuously -> grant order D,D,D,F,D,D,D,F, with starve_cnt reading 0,1,2,3,0 across the first F.
REQ-030 reset pulsed 1 cycle at cycle 2 of a data read -> no d_rvalid, busy=0 next cycle, a new if_req is granted normally afterwards.
REQ-031 Over all scenarios -> never two gnt or two rvalid in one cycle, and mem_en=0 outside ISSUE.
